up_ctr: RTL and testbench
=========================

UP_CTR -- requirements
Module: up_ctr

Interface
REQ-001 Parameter WIDTH, default 5: counter width in bits; legal range 2..16.
REQ-002 Parameter MODULUS, default 2**WIDTH: count sequence length; legal range 2..2**WIDTH.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset.
REQ-005 Port out  output  WIDTH: current count value, driven directly from a register.
REQ-006 Port tc  output  1: terminal-count indicator; present only when UP_CTR_TC_EN is defined.

Function
REQ-007 While rst is high, out SHALL increment by exactly 1 on every rising clk edge; there is no enable or hold input.
REQ-008 When out equals MODULUS-1, the next rising edge SHALL load 0 (wrap-around), never MODULUS.
REQ-009 With default parameters, the sequence SHALL be 0,1,...,31,0,... with one step per clock.
REQ-010 Latency SHALL be one clock: the first increment after rst rises SHALL appear on the first rising edge that follows the rise of rst.
REQ-011 Arithmetic SHALL be unsigned and WIDTH bits wide; no intermediate value SHALL exceed WIDTH bits after the wrap check.
REQ-012 out SHALL be glitch-free, i.e. registered with no combinational path from any input to out.
REQ-013 A rise of rst coincident with a rising clk edge SHALL leave out at 0 for that edge; counting starts at the next edge.

Reset
REQ-014 When rst goes low, out SHALL become 0 immediately, independent of clk.
REQ-015 While rst is low, out SHALL stay 0 and tc (if present) SHALL stay 0.
REQ-016 Reset asserted mid-count SHALL abort the sequence; after release, counting SHALL restart from 0.

Configuration
REQ-017 Macro UP_CTR_TC_EN defined: the tc port SHALL exist and SHALL be a registered signal that is 1 for exactly the one cycle during which out equals MODULUS-1, and 0 otherwise.
REQ-018 UP_CTR_TC_EN undefined: the tc port and all of its logic SHALL be absent; out behaviour SHALL be identical to the defined case.

Structure
REQ-019 Package up_ctr_pkg SHALL hold the default WIDTH constant (5) and a count_t typedef of that width.
REQ-020 Terminal-count detection (comparison against MODULUS-1) SHALL live in a sub-module named up_ctr_tc_det, shared by the wrap logic and the tc register.
REQ-021 The block SHALL be a single clock domain containing no latches and no other sub-modules.

Verification
REQ-022 Hold rst=0 for 5 time units with clk period 10, then release -> out=0 during reset, and out=1 at the first rising edge after release.
REQ-023 Run 31 clocks after release -> out=31, with tc=1 when UP_CTR_TC_EN is defined; the next edge -> out=0 and tc=0.
REQ-024 Run 32 clocks after release -> out=0, completing one full wrap with no skipped or repeated value.
REQ-025 Drive rst low when out=13, between clock edges -> out=0 immediately; release rst -> out=1 after one edge.
REQ-026 Set MODULUS=10 with WIDTH=5 -> sequence 0..9,0; out never reaches 10.
REQ-027 Build with and without UP_CTR_TC_EN -> identical out traces over 64 cycles.

Source files
------------

// File: rtl/up_ctr_pkg.sv
// Shared constants and types for the up_ctr counter block.
package up_ctr_pkg;

    // Default counter width; the top and detector fall back to this.
    localparam int unsigned DEFAULT_WIDTH = 5;

    // Count value at the default width.
    typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : up_ctr_pkg

// File: rtl/up_ctr_tc_det.sv
// Terminal-count detector for up_ctr: flags the last value of the sequence.
// With UP_CTR_TC_EN defined it also flags the value one before the last,
// so the registered tc output lines up with the cycle where out is last.
module up_ctr_tc_det
    import up_ctr_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] value,
    output logic             is_term
`ifdef UP_CTR_TC_EN
    ,
    output logic             is_pre
`endif
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    // Last value of the count sequence
    always_comb begin
        is_term = (value == LAST);
    end

`ifdef UP_CTR_TC_EN
    localparam logic [WIDTH-1:0] PRE = WIDTH'(MODULUS - 2);

    // Value whose successor is the last one; registered into tc
    always_comb begin
        is_pre = (value == PRE);
    end
`endif

endmodule : up_ctr_tc_det

// File: rtl/up_ctr.sv
// Free-running modulo-MODULUS up counter, asynchronous active-low reset.
// Optional feature macro: UP_CTR_TC_EN adds a registered terminal-count
// output tc that is high for the one cycle where out == MODULUS-1.
module up_ctr
    import up_ctr_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out
`ifdef UP_CTR_TC_EN
    ,
    output logic             tc
`endif
);

    logic             is_term;
    logic [WIDTH-1:0] cnt_next;

`ifdef UP_CTR_TC_EN
    logic             is_pre;

    up_ctr_tc_det #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_det (
        .value   (out),
        .is_term (is_term),
        .is_pre  (is_pre)
    );
`else
    up_ctr_tc_det #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_det (
        .value   (out),
        .is_term (is_term)
    );
`endif

    // Next count: wrap to zero after the last value, else add one
    always_comb begin
        cnt_next = out + WIDTH'(1);
        if (is_term) begin
            cnt_next = '0;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else begin
            out <= cnt_next;
        end
    end

`ifdef UP_CTR_TC_EN
    // tc is loaded one value early so it is high exactly while out is last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc <= 1'b0;
        end else begin
            tc <= is_pre;
        end
    end
`endif

endmodule : up_ctr

// File: tb/tb_up_ctr.sv
// Directed testbench for up_ctr: default instance (mod 32) and a
// WIDTH=5 / MODULUS=10 instance driven from the same clock and reset.
module tb_up_ctr;

    logic       clk;
    logic       rst;
    logic [4:0] out32;
    logic [4:0] out10;
`ifdef UP_CTR_TC_EN
    logic       tc32;
    logic       tc10;
`endif

    int unsigned n_cmp;
    int unsigned n_bad;

    up_ctr u_dut32 (
        .clk (clk),
        .rst (rst),
        .out (out32)
`ifdef UP_CTR_TC_EN
        ,
        .tc  (tc32)
`endif
    );

    up_ctr #(
        .WIDTH   (5),
        .MODULUS (10)
    ) u_dut10 (
        .clk (clk),
        .rst (rst),
        .out (out10)
`ifdef UP_CTR_TC_EN
        ,
        .tc  (tc10)
`endif
    );

    // Period 10; clk starts high so the first rising edge is at t=10.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;

        // Reset held low from t=0
        #2;
        chk("rst_out32", out32, 0);
        chk("rst_out10", out10, 0);
`ifdef UP_CTR_TC_EN
        chk("rst_tc32", tc32, 0);
        chk("rst_tc10", tc10, 0);
`endif

        // Release at t=5, between edges; first rising edge at t=10
        #3;
        rst = 1'b1;
        #2;
        chk("rel_out32", out32, 0);

        // Edges 1..64 after release: out32 = k mod 32, out10 = k mod 10
        for (int k = 1; k <= 64; k++) begin
            tick();
            chk($sformatf("seq32_%0d", k), out32, k % 32);
            chk($sformatf("seq10_%0d", k), out10, k % 10);
            chk($sformatf("lt10_%0d", k), (out10 < 5'd10) ? 1 : 0, 1);
`ifdef UP_CTR_TC_EN
            chk($sformatf("tc32_%0d", k), tc32, ((k % 32) == 31) ? 1 : 0);
            chk($sformatf("tc10_%0d", k), tc10, ((k % 10) == 9) ? 1 : 0);
`endif
        end
        // After 64 edges: out32 = 0, out10 = 4

        // Run to out32 = 13 (out10 = (4+13) mod 10 = 7)
        for (int k = 0; k < 13; k++) begin
            tick();
        end
        chk("pre_abort32", out32, 13);
        chk("pre_abort10", out10, 7);

        // Assert reset between edges: clears without a clock edge
        #2;
        rst = 1'b0;
        #1;
        chk("abort_out32", out32, 0);
        chk("abort_out10", out10, 0);
`ifdef UP_CTR_TC_EN
        chk("abort_tc32", tc32, 0);
`endif

        // Held in reset across an edge
        tick();
        chk("hold_out32", out32, 0);
        chk("hold_out10", out10, 0);

        // Release between edges; one edge later counting resumes from 0
        #2;
        rst = 1'b1;
        #1;
        chk("rel2_out32", out32, 0);
        tick();
        chk("restart_out32", out32, 1);
        chk("restart_out10", out10, 1);
        tick();
        chk("restart2_out32", out32, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_up_ctr
